// File: rtl/sop_mac_seq.sv
// sop_mac_seq: sequential sum-of-products over an internal operand register file, one pair per clock.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+NPAIRS (busy for NPAIRS cycles).
// Backpressure: none queued; start and operand writes are dropped while busy, rd port is always live.
module sop_mac_seq #(
  parameter int  WIDTH     = 8,
  parameter int  NPAIRS    = 2,
  parameter int  OUT_WIDTH = 16,
  localparam int AW        = $clog2(2*NPAIRS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [WIDTH-1:0]     i_wr_data,
  input  logic [AW-1:0]        i_rd_addr,
  output logic [WIDTH-1:0]     o_rd_data,
  input  logic                 i_start,
  input  logic                 i_accum,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [OUT_WIDTH-1:0] o_result,
  output logic                 o_overflow
);

  localparam int NOPS = 2*NPAIRS;
  localparam int IW   = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam int PW   = 2*WIDTH;
  // Sum width keeps every bit that could be discarded: the carry out of the
  // accumulator and any product bits above OUT_WIDTH.
  localparam int SW   = ((PW > OUT_WIDTH) ? PW : OUT_WIDTH) + 1;
  localparam logic [AW:0]   NOPS_A   = (AW+1)'(NOPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPAIRS-1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_x [NOPS];
  logic [IW-1:0]        r_idx;
  logic [OUT_WIDTH-1:0] r_acc;
  logic                 r_ovf_run;
  logic [OUT_WIDTH-1:0] r_result;
  logic                 r_overflow;
  logic                 r_done;

  logic [AW-1:0]        w_addr_a;
  logic [AW-1:0]        w_addr_b;
  logic [PW-1:0]        w_prod;
  logic [SW-1:0]        w_sum;
  logic                 w_carry;
  logic                 w_wr_ok;

  // Datapath: operand pair selected by the pair index, shared multiplier, widened adder.
  always_comb begin
    w_addr_a = AW'({r_idx, 1'b0});
    w_addr_b = w_addr_a | AW'(1);
    w_prod   = {{WIDTH{1'b0}}, r_x[w_addr_a]} * {{WIDTH{1'b0}}, r_x[w_addr_b]};
    w_sum    = SW'(r_acc) + SW'(w_prod);
    w_carry  = |w_sum[SW-1:OUT_WIDTH];
    w_wr_ok  = i_wr_en && (r_state == S_IDLE) && ({1'b0, i_wr_addr} < NOPS_A);
  end

  // Display read port: combinational, zero for indices past the register file.
  always_comb begin
    o_rd_data = '0;
    if ({1'b0, i_rd_addr} < NOPS_A) o_rd_data = r_x[i_rd_addr];
  end

  // Operand register file: writes only land while idle so a run sees stable operands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NOPS; i++) r_x[i] <= '0;
    end else if (w_wr_ok) begin
      r_x[i_wr_addr] <= i_wr_data;
    end
  end

  // Control FSM: accept start in IDLE, step one pair per clock in RUN, publish on the last pair.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_acc      <= '0;
      r_ovf_run  <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_RUN;
            r_idx     <= '0;
            r_acc     <= i_accum ? r_result : '0;
            r_ovf_run <= 1'b0;
          end
        end
        S_RUN: begin
          r_acc     <= w_sum[OUT_WIDTH-1:0];
          r_ovf_run <= r_ovf_run | w_carry;
          if (r_idx == LAST_IDX) begin
            r_result   <= w_sum[OUT_WIDTH-1:0];
            r_overflow <= r_ovf_run | w_carry;
            r_done     <= 1'b1;
            r_idx      <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state == S_RUN);
  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_overflow = r_overflow;

endmodule
